// File: rtl/pattern_checker.sv
// pattern_checker: receive-side checker for the video test-pattern stream.
// It locks to the f_sync/sync framing and recomputes the expected pixel for
// every accepted sample. It counts mismatches, short lines and overruns, and
// gives a pass/fail verdict for each frame.
// Optional feature: define PATTERN_CHECKER_FIRST_ERR_EN to capture the line,
// pixel, expected value and received value of the first error in each frame.
// Without it the first_err_* ports are tied to zero.
module pattern_checker #(
    parameter int LINES = 24,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             f_sync,
    input  logic             sync,
    input  logic [2:0]       Mode,
    input  logic [11:0]      constVal,
    input  logic [1:0]       X,
    input  logic [1:0]       Y,
    input  logic             pix_valid,
    input  logic [11:0]      pix_in,
    output logic [ERR_W-1:0] err_cnt,
    output logic             frame_done,
    output logic             frame_pass,
    output logic             cfg_err,
    output logic [1:0]       state,
    output logic [4:0]       first_err_line,
    output logic [11:0]      first_err_pix,
    output logic [11:0]      first_err_exp,
    output logic [11:0]      first_err_got
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LINE = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    localparam logic [2:0] MODE_NONE    = 3'b000;
    localparam logic [2:0] MODE_REGULAR = 3'b001;
    localparam logic [2:0] MODE_CONST   = 3'b010;
    localparam logic [2:0] MODE_WHITE1  = 3'b011;
    localparam logic [2:0] MODE_BLACK1  = 3'b100;
    localparam logic [2:0] MODE_WHITE2  = 3'b101;
    localparam logic [2:0] MODE_BLACK2  = 3'b110;
    localparam logic [2:0] MODE_RAMP    = 3'b111;

    localparam logic [4:0]       LINE_LAST      = 5'(LINES - 1);
    localparam logic [11:0]      LAST_PIX_REG   = 12'd4095;
    localparam logic [11:0]      LAST_PIX_OTHER = 12'd1289;
    localparam logic [ERR_W-1:0] ERR_MAX        = '1;

    state_t           state_q, state_d;
    logic [4:0]       line_q, line_d;
    logic [11:0]      pix_q, pix_d;
    logic [2:0]       mode_q, mode_d;
    logic [11:0]      const_q, const_d;
    logic [11:0]      dx_q, dx_d;
    logic [11:0]      dy_q, dy_d;
    logic [11:0]      row_q, row_d;
    logic [11:0]      ramp_q, ramp_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             cfg_q, cfg_d;

    logic             start_req;
    logic             frame_start;
    logic             err_inc;
    logic             pix_err;
    logic             advance;
    logic [11:0]      exp_pix;
    logic [11:0]      last_pix;
    logic [11:0]      dx_sel;
    logic [11:0]      dy_sel;

    // A frame start with Mode=000 is refused and only flags cfg_err.
    assign start_req   = f_sync & sync;
    assign frame_start = start_req & (Mode != MODE_NONE);

    // REGULAR lines carry the full 12-bit Gray sequence. Every other mode uses 1290-pixel lines.
    assign last_pix = (mode_q == MODE_REGULAR) ? LAST_PIX_REG : LAST_PIX_OTHER;

    // Decode the ramp step codes into per-pixel and per-line increments.
    always_comb begin
        dx_sel = 12'd0;
        dy_sel = 12'd0;
        case (X)
            2'b00:   dx_sel = 12'd0;
            2'b01:   dx_sel = 12'd1;
            2'b10:   dx_sel = 12'd4;
            default: dx_sel = 12'd8;
        endcase
        case (Y)
            2'b00:   dy_sel = 12'd0;
            2'b01:   dy_sel = 12'd1;
            2'b10:   dy_sel = 12'd16;
            default: dy_sel = 12'd1290;
        endcase
    end

    // Expected pixel for the current (line, pix) position in the latched mode.
    always_comb begin
        exp_pix = 12'h000;
        case (mode_q)
            MODE_REGULAR: exp_pix = pix_q ^ (pix_q >> 1);
            MODE_CONST:   exp_pix = const_q;
            MODE_WHITE1:  exp_pix = {12{pix_q[0] ^ line_q[0]}};
            MODE_BLACK1:  exp_pix = {12{~(pix_q[0] ^ line_q[0])}};
            MODE_WHITE2:  exp_pix = {12{pix_q[1] ^ line_q[1]}};
            MODE_BLACK2:  exp_pix = {12{~(pix_q[1] ^ line_q[1])}};
            MODE_RAMP:    exp_pix = ramp_q;
            default:      exp_pix = 12'h000;
        endcase
    end

    // Next-state logic. A frame start beats any sync action, and a sync action beats a pixel.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        pix_d   = pix_q;
        mode_d  = mode_q;
        const_d = const_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        row_d   = row_q;
        ramp_d  = ramp_q;
        err_d   = err_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        cfg_d   = cfg_q;
        err_inc = 1'b0;
        pix_err = 1'b0;
        advance = 1'b0;

        if (frame_start) begin
            state_d = ST_LINE;
            mode_d  = Mode;
            const_d = constVal;
            dx_d    = dx_sel;
            dy_d    = dy_sel;
            line_d  = 5'd0;
            pix_d   = 12'd0;
            row_d   = 12'd0;
            ramp_d  = 12'd0;
            err_d   = '0;
        end else if (start_req) begin
            // Refused start: abandon any frame in progress without a verdict.
            cfg_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_LINE: begin
                    if (sync) begin
                        err_inc = 1'b1;
                        advance = 1'b1;
                    end else if (pix_valid) begin
                        pix_err = (pix_in != exp_pix);
                        err_inc = pix_err;
                        ramp_d  = ramp_q + dx_q;
                        if (pix_q == last_pix) begin
                            if (line_q == LINE_LAST) begin
                                advance = 1'b1;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end else begin
                            pix_d = pix_q + 12'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sync) begin
                        advance = 1'b1;
                    end else if (pix_valid) begin
                        err_inc = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            if (err_inc && (err_q != ERR_MAX)) begin
                err_d = err_q + 1'b1;
            end

            if (advance) begin
                if (line_q == LINE_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_LINE;
                    line_d  = line_q + 5'd1;
                    pix_d   = 12'd0;
                    row_d   = row_q + dy_q;
                    ramp_d  = row_q + dy_q;
                end
            end
        end
    end

    // State and datapath registers, all cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            line_q  <= 5'd0;
            pix_q   <= 12'd0;
            mode_q  <= MODE_NONE;
            const_q <= 12'd0;
            dx_q    <= 12'd0;
            dy_q    <= 12'd0;
            row_q   <= 12'd0;
            ramp_q  <= 12'd0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            pix_q   <= pix_d;
            mode_q  <= mode_d;
            const_q <= const_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            row_q   <= row_d;
            ramp_q  <= ramp_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cfg_q   <= cfg_d;
        end
    end

    assign err_cnt    = err_q;
    assign frame_done = done_q;
    assign frame_pass = pass_q;
    assign cfg_err    = cfg_q;
    assign state      = state_q;

`ifdef PATTERN_CHECKER_FIRST_ERR_EN
    logic        err_seen_q;
    logic [4:0]  fe_line_q;
    logic [11:0] fe_pix_q;
    logic [11:0] fe_exp_q;
    logic [11:0] fe_got_q;

    // Record where the first error of each frame occurred. Short-line and overrun errors store zero values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seen_q <= 1'b0;
            fe_line_q  <= 5'd0;
            fe_pix_q   <= 12'd0;
            fe_exp_q   <= 12'd0;
            fe_got_q   <= 12'd0;
        end else if (frame_start) begin
            err_seen_q <= 1'b0;
            fe_line_q  <= 5'd0;
            fe_pix_q   <= 12'd0;
            fe_exp_q   <= 12'd0;
            fe_got_q   <= 12'd0;
        end else if (err_inc && !err_seen_q) begin
            err_seen_q <= 1'b1;
            fe_line_q  <= line_q;
            fe_pix_q   <= pix_q;
            fe_exp_q   <= pix_err ? exp_pix : 12'd0;
            fe_got_q   <= pix_err ? pix_in : 12'd0;
        end
    end

    assign first_err_line = fe_line_q;
    assign first_err_pix  = fe_pix_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_got  = fe_got_q;
`else
    assign first_err_line = 5'd0;
    assign first_err_pix  = 12'd0;
    assign first_err_exp  = 12'd0;
    assign first_err_got  = 12'd0;
`endif

endmodule

// File: tb/tb_pattern_checker.sv
// tb_pattern_checker: directed self-checking bench for pattern_checker.
// It uses a 4-line frame and a 4-bit error counter. This keeps whole frames
// short and makes counter saturation reachable.
module tb_pattern_checker;

    localparam int LINES = 4;
    localparam int ERR_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             f_sync;
    logic             sync;
    logic [2:0]       Mode;
    logic [11:0]      constVal;
    logic [1:0]       X;
    logic [1:0]       Y;
    logic             pix_valid;
    logic [11:0]      pix_in;
    logic [ERR_W-1:0] err_cnt;
    logic             frame_done;
    logic             frame_pass;
    logic             cfg_err;
    logic [1:0]       state;
    logic [4:0]       first_err_line;
    logic [11:0]      first_err_pix;
    logic [11:0]      first_err_exp;
    logic [11:0]      first_err_got;

    int checks = 0;
    int errors = 0;

    logic [2:0]  cur_mode;
    logic [11:0] cur_const;
    logic [1:0]  cur_x;
    logic [1:0]  cur_y;

    // Free-running 100 MHz pixel clock.
    always #5 clk = ~clk;

    pattern_checker #(.LINES(LINES), .ERR_W(ERR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .f_sync         (f_sync),
        .sync           (sync),
        .Mode           (Mode),
        .constVal       (constVal),
        .X              (X),
        .Y              (Y),
        .pix_valid      (pix_valid),
        .pix_in         (pix_in),
        .err_cnt        (err_cnt),
        .frame_done     (frame_done),
        .frame_pass     (frame_pass),
        .cfg_err        (cfg_err),
        .state          (state),
        .first_err_line (first_err_line),
        .first_err_pix  (first_err_pix),
        .first_err_exp  (first_err_exp),
        .first_err_got  (first_err_got)
    );

    // Reference pixel straight from the pattern definitions. The ramp uses direct multiplication.
    function automatic logic [11:0] model_pixel(input int l, input int i);
        int dx;
        int dy;
        case (cur_x)
            2'b00:   dx = 0;
            2'b01:   dx = 1;
            2'b10:   dx = 4;
            default: dx = 8;
        endcase
        case (cur_y)
            2'b00:   dy = 0;
            2'b01:   dy = 1;
            2'b10:   dy = 16;
            default: dy = 1290;
        endcase
        case (cur_mode)
            3'b001:  return 12'(i ^ (i >> 1));
            3'b010:  return cur_const;
            3'b011:  return (((i + l) % 2) == 1) ? 12'hFFF : 12'h000;
            3'b100:  return (((i + l) % 2) == 1) ? 12'h000 : 12'hFFF;
            3'b101:  return ((((i >> 1) + (l >> 1)) % 2) == 1) ? 12'hFFF : 12'h000;
            3'b110:  return ((((i >> 1) + (l >> 1)) % 2) == 1) ? 12'h000 : 12'hFFF;
            3'b111:  return 12'((l * dy + i * dx) % 4096);
            default: return 12'h000;
        endcase
    endfunction

    function automatic int line_len();
        return (cur_mode == 3'b001) ? 4096 : 1290;
    endfunction

    // Drive one cycle of framing and pixel inputs, then settle just after the edge.
    task automatic applyStimulus(input logic fs, input logic s, input logic pv, input logic [11:0] px);
        f_sync    = fs;
        sync      = s;
        pix_valid = pv;
        pix_in    = px;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue a frame start, then scramble the config inputs so the checker must rely on its latched copy.
    task automatic startFrame(input logic [2:0] m, input logic [11:0] cv, input logic [1:0] x, input logic [1:0] y);
        cur_mode  = m;
        cur_const = cv;
        cur_x     = x;
        cur_y     = y;
        Mode      = m;
        constVal  = cv;
        X         = x;
        Y         = y;
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        Mode      = 3'b000;
        constVal  = ~cv;
        X         = ~x;
        Y         = ~y;
    endtask

    task automatic sendLine(input int l, input int npix, input int bad_pix, input logic [11:0] bad_val);
        logic [11:0] v;
        for (int p = 0; p < npix; p++) begin
            v = model_pixel(l, p);
            if (p == bad_pix) v = bad_val;
            applyStimulus(1'b0, 1'b0, 1'b1, v);
        end
    endtask

    // Idle cycle followed by a line sync.
    task automatic lineGap();
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
    endtask

    task automatic sendFrame(input int bad_line, input int bad_pix, input logic [11:0] bad_val);
        for (int l = 0; l < LINES; l++) begin
            if (l > 0) lineGap();
            sendLine(l, line_len(), (l == bad_line) ? bad_pix : -1, bad_val);
            if (l < LINES - 1) checkOutput("wait_state", state, 2'b10);
        end
    endtask

    // Upper bound on run time so the bench always terminates.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence covering reset, each pattern family, framing faults and saturation.
    initial begin
        logic [11:0] badv;
        rst_n     = 1'b0;
        f_sync    = 1'b0;
        sync      = 1'b0;
        Mode      = 3'b000;
        constVal  = 12'h000;
        X         = 2'b00;
        Y         = 2'b00;
        pix_valid = 1'b0;
        pix_in    = 12'h000;
        cur_mode  = 3'b000;
        cur_const = 12'h000;
        cur_x     = 2'b00;
        cur_y     = 2'b00;

        #3;
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_frame_pass", frame_pass, 0);
        checkOutput("rst_cfg_err", cfg_err, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_first_line", first_err_line, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] frame start with Mode=000");
        Mode = 3'b000;
        applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
        checkOutput("cfg_err_set", cfg_err, 1);
        checkOutput("cfg_state_idle", state, 0);

        $display("[TB] REGULAR clean frame");
        startFrame(3'b001, 12'h000, 2'b00, 2'b00);
        checkOutput("reg_state_line", state, 1);
        sendFrame(-1, -1, 12'h000);
        checkOutput("reg_done", frame_done, 1);
        checkOutput("reg_pass", frame_pass, 1);
        checkOutput("reg_err_cnt", err_cnt, 0);
        checkOutput("reg_state_idle", state, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
        checkOutput("reg_done_pulse", frame_done, 0);

        $display("[TB] CONST frame with one bad pixel");
        startFrame(3'b010, 12'hA5C, 2'b00, 2'b00);
        sendFrame(3, 100, 12'hA5D);
        checkOutput("const_done", frame_done, 1);
        checkOutput("const_err_cnt", err_cnt, 1);
        checkOutput("const_pass", frame_pass, 0);
`ifdef PATTERN_CHECKER_FIRST_ERR_EN
        checkOutput("const_first_line", first_err_line, 3);
        checkOutput("const_first_pix", first_err_pix, 100);
        checkOutput("const_first_exp", first_err_exp, 12'hA5C);
        checkOutput("const_first_got", first_err_got, 12'hA5D);
`else
        checkOutput("const_first_line", first_err_line, 0);
        checkOutput("const_first_got", first_err_got, 0);
`endif

        $display("[TB] RAMP frame X=10 Y=11");
        startFrame(3'b111, 12'h000, 2'b10, 2'b11);
        sendFrame(2, 5, 12'hA28);
        checkOutput("ramp_done", frame_done, 1);
        checkOutput("ramp_err_cnt", err_cnt, 0);
        checkOutput("ramp_pass", frame_pass, 1);

        $display("[TB] WHITE2x2 frame with short line 2");
        startFrame(3'b101, 12'h000, 2'b00, 2'b00);
        sendLine(0, 1290, -1, 12'h000);
        lineGap();
        sendLine(1, 1290, -1, 12'h000);
        lineGap();
        sendLine(2, 600, -1, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        checkOutput("short_err_cnt", err_cnt, 1);
        checkOutput("short_state", state, 1);
        sendLine(3, 1290, -1, 12'h000);
        checkOutput("short_done", frame_done, 1);
        checkOutput("short_final_err", err_cnt, 1);
        checkOutput("short_pass", frame_pass, 0);
`ifdef PATTERN_CHECKER_FIRST_ERR_EN
        checkOutput("short_first_line", first_err_line, 2);
        checkOutput("short_first_pix", first_err_pix, 600);
        checkOutput("short_first_exp", first_err_exp, 0);
`endif

        $display("[TB] resync mid line 2");
        startFrame(3'b011, 12'h000, 2'b00, 2'b00);
        sendLine(0, 1290, -1, 12'h000);
        lineGap();
        badv = ~model_pixel(1, 7);
        sendLine(1, 1290, 7, badv);
        lineGap();
        sendLine(2, 300, -1, 12'h000);
        checkOutput("resync_pre_err", err_cnt, 1);
        startFrame(3'b110, 12'h000, 2'b00, 2'b00);
        checkOutput("resync_no_done", frame_done, 0);
        checkOutput("resync_err_clr", err_cnt, 0);
        checkOutput("resync_state", state, 1);
        sendFrame(-1, -1, 12'h000);
        checkOutput("resync_done", frame_done, 1);
        checkOutput("resync_pass", frame_pass, 1);
        checkOutput("resync_first_line", first_err_line, 0);

        $display("[TB] reset during line 2 of BLACK1x1");
        startFrame(3'b100, 12'h000, 2'b00, 2'b00);
        sendLine(0, 1290, -1, 12'h000);
        lineGap();
        sendLine(1, 1290, -1, 12'h000);
        lineGap();
        badv = ~model_pixel(2, 20);
        sendLine(2, 500, 20, badv);
        checkOutput("rst_mid_pre_err", err_cnt, 1);
        pix_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_err_cnt", err_cnt, 0);
        checkOutput("rst_mid_state", state, 0);
        checkOutput("rst_mid_pass", frame_pass, 0);
        checkOutput("rst_mid_cfg", cfg_err, 0);
        checkOutput("rst_mid_done", frame_done, 0);
        checkOutput("rst_mid_first_line", first_err_line, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 12'h123);
        checkOutput("idle_ignores_state", state, 0);
        checkOutput("idle_ignores_err", err_cnt, 0);
        startFrame(3'b100, 12'h000, 2'b00, 2'b00);
        sendFrame(-1, -1, 12'h000);
        checkOutput("post_rst_done", frame_done, 1);
        checkOutput("post_rst_pass", frame_pass, 1);
        checkOutput("post_rst_err", err_cnt, 0);

        $display("[TB] overrun, saturation and short last line");
        startFrame(3'b010, 12'h123, 2'b00, 2'b00);
        sendLine(0, 1290, -1, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b1, 12'hFFF);
        checkOutput("sync_pix_state", state, 1);
        checkOutput("sync_pix_err", err_cnt, 0);
        sendLine(1, 1290, -1, 12'h000);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1, 12'h123);
        checkOutput("overrun_err", err_cnt, 3);
        for (int k = 0; k < 17; k++) applyStimulus(1'b0, 1'b0, 1'b1, 12'h123);
        checkOutput("sat_err", err_cnt, 15);
        checkOutput("sat_state", state, 2);
`ifdef PATTERN_CHECKER_FIRST_ERR_EN
        checkOutput("overrun_first_line", first_err_line, 1);
        checkOutput("overrun_first_got", first_err_got, 0);
`endif
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        checkOutput("short_l2_done", frame_done, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 12'h000);
        checkOutput("short_last_done", frame_done, 1);
        checkOutput("short_last_pass", frame_pass, 0);
        checkOutput("short_last_state", state, 0);
        checkOutput("short_last_err", err_cnt, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_checker.md
# pattern_checker

Receive-side checker for the video test-pattern stream. It sits at the sink of the pixel path and locks to the same `f_sync`/`sync` framing and the same `Mode`/`constVal`/`X`/`Y` configuration as the pattern generator. It recomputes the expected pixel for every accepted sample, counts mismatches and framing faults, and reports a per-frame pass/fail verdict.

## Interface
Parameters:
- `LINES`, 24: lines per frame.
- `ERR_W`, 16: error counter width.

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `f_sync`, in, 1: first-sync. `f_sync & sync` marks the start of a frame.
- `sync`, in, 1: line start.
- `Mode`, in, 3: pattern mode. 001 REGULAR, 010 CONST, 011 WHITE1x1, 100 BLACK1x1, 101 WHITE2x2, 110 BLACK2x2, 111 RAMP.
- `constVal`, in, 12: CONST value.
- `X`, in, 2: ramp deltaX code. 00→0, 01→1, 10→4, 11→8.
- `Y`, in, 2: ramp deltaY code. 00→0, 01→1, 10→16, 11→1290.
- `pix_valid`, in, 1: `pix_in` is valid this cycle.
- `pix_in`, in, 12: received pixel.
- `err_cnt`, out, ERR_W: saturating error count for the current frame.
- `frame_done`, out, 1: one-cycle pulse at the end of a frame.
- `frame_pass`, out, 1: verdict of the last completed frame, 1 = zero errors.
- `cfg_err`, out, 1: sticky flag, set when a frame start sees Mode=000.
- `state`, out, 2: FSM state, for debug.
- `first_err_line`/`first_err_pix`/`first_err_exp`/`first_err_got`, out, 5/12/12/12: see Configuration.

## Operation
- States: IDLE(00), LINE(01), WAIT(10).
- IDLE:
  - `f_sync & sync` with Mode≠000 → LINE.
  - On that transition, latch Mode, constVal, deltaX and deltaY, and clear `line`, `pix` and `err_cnt`.
  - Mode=000 at a frame start sets `cfg_err` and the FSM stays in IDLE.
  - `pix_valid` is ignored.
- Line length L: 4096 for REGULAR, 1290 for every other mode.
- LINE:
  - Each cycle with `pix_valid`: compare `pix_in` with exp(line, pix). A mismatch adds 1 to `err_cnt`. Then `pix` increments.
  - When the accepted pixel has `pix`=L-1 → WAIT.
- Expected values (i = `pix`, l = `line`, all arithmetic mod 4096):
  - REGULAR: i ^ (i>>1), i.e. Gray code.
  - CONST: latched constVal.
  - WHITE1x1: FFF if (i+l) is odd, else 000. BLACK1x1 is the inverse.
  - WHITE2x2: FFF if ((i>>1)+(l>>1)) is odd, else 000. BLACK2x2 is the inverse.
  - RAMP: l·deltaY + i·deltaX. Maintain it incrementally: a row base accumulates deltaY per line, and a running value accumulates deltaX per pixel. No multipliers.
- WAIT:
  - `sync` and line<LINES-1 → LINE, line+1, pix=0.
  - `pix_valid` in WAIT is an overrun: +1 error per cycle.
- Frame end: after the last pixel of line LINES-1 is accepted → IDLE, and `frame_done` pulses. `frame_pass` is loaded with (final `err_cnt` == 0), where the final count includes that last pixel.
- `sync` in LINE with pix<L is a short line:
  - +1 error.
  - Advance to the next line with pix=0.
  - If it was line LINES-1, end the frame as above.
- `f_sync & sync` while in LINE or WAIT: resynchronise.
  - Restart the frame: relatch config and clear counters.
  - No `frame_done` pulse.
  - This has priority over plain `sync` handling.
- Simultaneous `sync` and `pix_valid`: the sync action wins. The pixel is discarded, not counted.
- `err_cnt` saturates at 2^ERR_W-1.
- Reset values: `err_cnt`=0, `frame_done`=0, `frame_pass`=0, `cfg_err`=0, `state`=IDLE, all `first_err_*`=0.
- Reset mid-frame: everything clears asynchronously. After release the block waits in IDLE for the next `f_sync & sync`.

## Timing
- Comparison happens in the cycle the sample is presented. `err_cnt` reflects that sample on the next clock edge (1-cycle latency).
- `frame_done` and `frame_pass` update on the edge following the last accepted pixel.
- The frame-start cycle itself carries no pixel. The first pixel is accepted at the earliest one cycle after the sync.
- There is no backpressure: the checker accepts a pixel on every `pix_valid` cycle.

## Configuration
- `PATTERN_CHECKER_FIRST_ERR_EN` defined:
  - On the first error of a frame, latch `first_err_line`, `first_err_pix`, `first_err_exp` and `first_err_got`.
  - For short-line and overrun errors, exp/got = 000.
  - These registers are cleared at frame start.
- Not defined: the `first_err_*` ports are present but tied to 0, and no capture logic is synthesised.

## Test plan
- REGULAR, 24 clean lines of Gray-coded 0..4095 → `frame_done` pulse, `frame_pass`=1, `err_cnt`=0.
- CONST, constVal=0xA5C, pixel 100 of line 3 sent as 0xA5D → `err_cnt`=1, `frame_pass`=0. With the macro defined: line=3, pix=100, exp=A5C, got=A5D.
- RAMP with X=10, Y=11 → line 2 pixel 5 expects (2·1290+20) mod 4096 = 0xA28. Clean frame → pass.
- WHITE2x2 with line 5 cut after 600 pixels by `sync` → exactly 1 error, remaining lines still checked, frame ends after line 23.
- `f_sync & sync` reissued mid line 10 → no `frame_done`, `err_cnt` cleared, new frame checked from line 0.
- Assert `rst_n` low during line 7 of a BLACK1x1 frame → all outputs 0 immediately, `state`=IDLE. The next full clean frame passes.
